// File: rtl/ppi8255_pkg.sv
// Shared constants and helpers for the 8255-style mode-0 parallel port.
// Address map, control-word bit positions and the reset control word live here.
package ppi8255_pkg;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_MODESET = 7;
  localparam int CTRL_A_IN    = 4;
  localparam int CTRL_CU_IN   = 3;
  localparam int CTRL_B_IN    = 1;
  localparam int CTRL_CL_IN   = 0;

  // All three ports as inputs, mode 0.
  localparam logic [7:0] CTRL_RESET = 8'h9B;

  // Bit set/reset command: cmd[3:1] picks the port-C bit, cmd[0] is its new value.
  function automatic logic [7:0] bsr_apply(input logic [7:0] lat, input logic [7:0] cmd);
    logic [7:0] res;
    res = lat;
    res[cmd[3:1]] = cmd[0];
    return res;
  endfunction

endpackage

// File: rtl/ppi8255_pin_mux.sv
// Direction-dependent selection for one port or port-C nibble: drives the
// pins high when the port is an input and picks the read-back source.
module ppi8255_pin_mux #(
  parameter int DATA_W = 8
) (
  input  logic              i_is_in,
  input  logic [DATA_W-1:0] i_lat,
  input  logic [DATA_W-1:0] i_pin,
  output logic [DATA_W-1:0] o_pin,
  output logic [DATA_W-1:0] o_rd
);

  // Input ports float high on the pins and read back the external level.
  assign o_pin = i_is_in ? {DATA_W{1'b1}} : i_lat;
  assign o_rd  = i_is_in ? i_pin          : i_lat;

endmodule

// File: rtl/ppi8255_port.sv
// Mode-0 8255 PPI: control word, three output latches and a combinational read mux.
// Port-C bit set/reset via control writes is enabled by defining PPI_BSR_EN.
module ppi8255_port
  import ppi8255_pkg::*;
(
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       i_rd_n,
  input  logic       i_wr_n,
  input  logic       i_cs_n,
  input  logic [7:0] i_pa,
  output logic [7:0] o_pa,
  input  logic [7:0] i_pb,
  output logic [7:0] o_pb,
  input  logic [7:0] i_pc,
  output logic [7:0] o_pc
);

  logic [7:0] r_ctrl;
  logic [7:0] r_lat_a;
  logic [7:0] r_lat_b;
  logic [7:0] r_lat_c;

  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_rd_a;
  logic [7:0] w_rd_b;
  logic [3:0] w_rd_cu;
  logic [3:0] w_rd_cl;
  logic [3:0] w_pin_cu;
  logic [3:0] w_pin_cl;

  assign w_wr = ~i_cs_n & ~i_wr_n;
  assign w_rd = ~i_cs_n & ~i_rd_n;

  // Writes are level-sensitive; reset wins over any write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_ctrl  <= CTRL_RESET;
      r_lat_a <= 8'h00;
      r_lat_b <= 8'h00;
      r_lat_c <= 8'h00;
    end else if (w_wr) begin
      case (i_addr)
        ADDR_PA: r_lat_a <= i_data;
        ADDR_PB: r_lat_b <= i_data;
        ADDR_PC: r_lat_c <= i_data;
        default: begin
          if (i_data[CTRL_MODESET]) begin
            r_ctrl  <= i_data;
            r_lat_a <= 8'h00;
            r_lat_b <= 8'h00;
            r_lat_c <= 8'h00;
          end
`ifdef PPI_BSR_EN
          else begin
            r_lat_c <= bsr_apply(r_lat_c, i_data);
          end
`endif
        end
      endcase
    end
  end

  ppi8255_pin_mux #(.DATA_W(8)) u_mux_a (
    .i_is_in (r_ctrl[CTRL_A_IN]),
    .i_lat   (r_lat_a),
    .i_pin   (i_pa),
    .o_pin   (o_pa),
    .o_rd    (w_rd_a)
  );

  ppi8255_pin_mux #(.DATA_W(8)) u_mux_b (
    .i_is_in (r_ctrl[CTRL_B_IN]),
    .i_lat   (r_lat_b),
    .i_pin   (i_pb),
    .o_pin   (o_pb),
    .o_rd    (w_rd_b)
  );

  ppi8255_pin_mux #(.DATA_W(4)) u_mux_cu (
    .i_is_in (r_ctrl[CTRL_CU_IN]),
    .i_lat   (r_lat_c[7:4]),
    .i_pin   (i_pc[7:4]),
    .o_pin   (w_pin_cu),
    .o_rd    (w_rd_cu)
  );

  ppi8255_pin_mux #(.DATA_W(4)) u_mux_cl (
    .i_is_in (r_ctrl[CTRL_CL_IN]),
    .i_lat   (r_lat_c[3:0]),
    .i_pin   (i_pc[3:0]),
    .o_pin   (w_pin_cl),
    .o_rd    (w_rd_cl)
  );

  assign o_pc = {w_pin_cu, w_pin_cl};

  // Read data is combinational and shows pre-edge state during a concurrent write.
  always_comb begin
    o_data = 8'h00;
    if (w_rd) begin
      case (i_addr)
        ADDR_PA: o_data = w_rd_a;
        ADDR_PB: o_data = w_rd_b;
        ADDR_PC: o_data = {w_rd_cu, w_rd_cl};
        default: o_data = r_ctrl;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi8255_port.sv
// Bench for ppi8255_port: directed scenarios plus randomized traffic against a mask-based model.
module tb_ppi8255_port;

  logic       i_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;
  logic       i_rd_n = 1'b1;
  logic       i_wr_n = 1'b1;
  logic       i_cs_n = 1'b1;
  logic [7:0] i_pa = 8'h00, i_pb = 8'h00, i_pc = 8'h00;
  logic [7:0] o_pa, o_pb, o_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_ctrl;
  logic [7:0] m_lat [3];

  ppi8255_port dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data), .i_rd_n(i_rd_n), .i_wr_n(i_wr_n), .i_cs_n(i_cs_n),
    .i_pa(i_pa), .o_pa(o_pa), .i_pb(i_pb), .o_pb(o_pb), .i_pc(i_pc), .o_pc(o_pc)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: input mask per port, pins = latch OR mask, read = blend by mask.
  function automatic logic [7:0] in_mask(int p);
    if (p == 0) return m_ctrl[4] ? 8'hFF : 8'h00;
    if (p == 1) return m_ctrl[1] ? 8'hFF : 8'h00;
    return {(m_ctrl[3] ? 4'hF : 4'h0), (m_ctrl[0] ? 4'hF : 4'h0)};
  endfunction

  function automatic logic [7:0] exp_pin(int p);
    return m_lat[p] | in_mask(p);
  endfunction

  function automatic logic [7:0] exp_rd(logic [1:0] a, logic [7:0] pa, logic [7:0] pb, logic [7:0] pc);
    logic [7:0] pin, m;
    if (a == 2'd3) return m_ctrl;
    pin = (a == 2'd0) ? pa : (a == 2'd1) ? pb : pc;
    m = in_mask(int'(a));
    return (pin & m) | (m_lat[a] & ~m);
  endfunction

  function automatic void model_reset();
    m_ctrl = 8'h9B;
    for (int k = 0; k < 3; k++) m_lat[k] = 8'h00;
  endfunction

  function automatic void model_write(logic [1:0] a, logic [7:0] d);
    if (a != 2'd3) m_lat[a] = d;
    else if (d[7]) begin
      m_ctrl = d;
      for (int k = 0; k < 3; k++) m_lat[k] = 8'h00;
    end
`ifdef PPI_BSR_EN
    else m_lat[2][d[3:1]] = d[0];
`endif
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    i_addr = a; i_data = d; i_cs_n = 1'b0; i_wr_n = 1'b0;
    @(posedge i_clk);
    model_write(a, d);
    #1;
    i_cs_n = 1'b1; i_wr_n = 1'b1;
  endtask

  task automatic start_read(input logic [1:0] a);
    i_addr = a; i_cs_n = 1'b0; i_rd_n = 1'b0;
    #1;
  endtask

  task automatic end_read();
    i_cs_n = 1'b1; i_rd_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    model_reset();
    #1;
    reset_n = 1'b1;
    n_tests++; if (o_pa !== 8'hFF) begin n_fail++; $display("FAIL reset_opa got=%h want=%h", o_pa, 8'hFF); end
    n_tests++; if (o_pb !== 8'hFF) begin n_fail++; $display("FAIL reset_opb got=%h want=%h", o_pb, 8'hFF); end
    n_tests++; if (o_pc !== 8'hFF) begin n_fail++; $display("FAIL reset_opc got=%h want=%h", o_pc, 8'hFF); end
    start_read(2'd3);
    n_tests++; if (o_data !== 8'h9B) begin n_fail++; $display("FAIL reset_ctrl got=%h want=%h", o_data, 8'h9B); end
    i_pa = 8'h5A;
    start_read(2'd0);
    n_tests++; if (o_data !== 8'h5A) begin n_fail++; $display("FAIL reset_rd_pa got=%h want=%h", o_data, 8'h5A); end
    end_read();
    n_tests++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL idle_rd got=%h want=%h", o_data, 8'h00); end
  endtask

  task automatic test_mode0();
    do_write(2'd3, 8'h82);
    do_write(2'd0, 8'h3C);
    n_tests++; if (o_pa !== 8'h3C) begin n_fail++; $display("FAIL m0_opa got=%h want=%h", o_pa, 8'h3C); end
    n_tests++; if (o_pc !== 8'h00) begin n_fail++; $display("FAIL m0_opc got=%h want=%h", o_pc, 8'h00); end
    n_tests++; if (o_pb !== 8'hFF) begin n_fail++; $display("FAIL m0_opb got=%h want=%h", o_pb, 8'hFF); end
    i_pb = 8'(($urandom));
    start_read(2'd1);
    n_tests++; if (o_data !== i_pb) begin n_fail++; $display("FAIL m0_rd_pb got=%h want=%h", o_data, i_pb); end
    end_read();
  endtask

  task automatic test_pc_nibbles();
    do_write(2'd3, 8'h81);
    do_write(2'd2, 8'hA5);
    i_pc = 8'h0F;
    #1;
    n_tests++; if (o_pc !== 8'hAF) begin n_fail++; $display("FAIL pcn_opc got=%h want=%h", o_pc, 8'hAF); end
    start_read(2'd2);
    n_tests++; if (o_data !== 8'hAF) begin n_fail++; $display("FAIL pcn_rd got=%h want=%h", o_data, 8'hAF); end
    end_read();
  endtask

  task automatic test_bsr();
    logic [7:0] w1, w2, w3;
`ifdef PPI_BSR_EN
    w1 = 8'h80; w2 = 8'h80; w3 = 8'h84;
`else
    w1 = 8'h00; w2 = 8'h00; w3 = 8'h00;
`endif
    do_write(2'd3, 8'h80);
    do_write(2'd3, 8'h0F);
    n_tests++; if (o_pc !== w1) begin n_fail++; $display("FAIL bsr_set7 got=%h want=%h", o_pc, w1); end
    do_write(2'd3, 8'h04);
    n_tests++; if (o_pc !== w2) begin n_fail++; $display("FAIL bsr_clr2 got=%h want=%h", o_pc, w2); end
    do_write(2'd3, 8'h05);
    n_tests++; if (o_pc !== w3) begin n_fail++; $display("FAIL bsr_set2 got=%h want=%h", o_pc, w3); end
    start_read(2'd3);
    n_tests++; if (o_data !== 8'h80) begin n_fail++; $display("FAIL bsr_ctrl got=%h want=%h", o_data, 8'h80); end
    end_read();
  endtask

  task automatic test_modeset_clears();
    do_write(2'd3, 8'h80);
    do_write(2'd0, 8'h77);
    n_tests++; if (o_pa !== 8'h77) begin n_fail++; $display("FAIL msc_load got=%h want=%h", o_pa, 8'h77); end
    do_write(2'd3, 8'h80);
    n_tests++; if (o_pa !== 8'h00) begin n_fail++; $display("FAIL msc_clear got=%h want=%h", o_pa, 8'h00); end
    i_addr = 2'd0; i_data = 8'h11; i_cs_n = 1'b1; i_wr_n = 1'b0;
    @(posedge i_clk); #1;
    i_wr_n = 1'b1;
    n_tests++; if (o_pa !== 8'h00) begin n_fail++; $display("FAIL msc_nocs got=%h want=%h", o_pa, 8'h00); end
  endtask

  task automatic test_rd_wr_same_cycle();
    i_addr = 2'd0; i_data = 8'hC3; i_cs_n = 1'b0; i_wr_n = 1'b0; i_rd_n = 1'b0;
    #1;
    n_tests++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL rdwr_pre got=%h want=%h", o_data, 8'h00); end
    @(posedge i_clk);
    model_write(2'd0, 8'hC3);
    #1;
    n_tests++; if (o_data !== 8'hC3) begin n_fail++; $display("FAIL rdwr_post got=%h want=%h", o_data, 8'hC3); end
    i_cs_n = 1'b1; i_wr_n = 1'b1; i_rd_n = 1'b1;
  endtask

  task automatic test_reset_override();
    i_addr = 2'd0; i_data = 8'h55; i_cs_n = 1'b0; i_wr_n = 1'b0;
    @(posedge i_clk); model_write(2'd0, 8'h55); #1;
    n_tests++; if (o_pa !== 8'h55) begin n_fail++; $display("FAIL rov_c1 got=%h want=%h", o_pa, 8'h55); end
    reset_n = 1'b0;
    @(posedge i_clk); model_reset(); #1;
    n_tests++; if ({o_pa, o_pb, o_pc} !== 24'hFFFFFF) begin n_fail++; $display("FAIL rov_c2 got=%h want=%h", {o_pa, o_pb, o_pc}, 24'hFFFFFF); end
    i_wr_n = 1'b1; i_rd_n = 1'b0; i_addr = 2'd3;
    #1;
    n_tests++; if (o_data !== 8'h9B) begin n_fail++; $display("FAIL rov_ctrl got=%h want=%h", o_data, 8'h9B); end
    i_rd_n = 1'b1; i_addr = 2'd0; i_wr_n = 1'b0;
    reset_n = 1'b1;
    @(posedge i_clk); model_write(2'd0, 8'h55); #1;
    i_cs_n = 1'b1; i_wr_n = 1'b1;
    n_tests++; if (o_pa !== 8'hFF) begin n_fail++; $display("FAIL rov_c3 got=%h want=%h", o_pa, 8'hFF); end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [7:0] d, exp;
    logic       wr, rst;
    for (int it = 0; it < 400; it++) begin
      i_pa = 8'($urandom); i_pb = 8'($urandom); i_pc = 8'($urandom);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd3 && $urandom_range(0, 2) != 0) a = 2'($urandom_range(0, 2));
      d = 8'($urandom);
      i_addr = a; i_data = d;
      i_cs_n = ($urandom_range(0, 3) == 0);
      i_wr_n = 1'($urandom_range(0, 1));
      i_rd_n = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      reset_n = ~rst;
      #1;
      exp = (!i_cs_n && !i_rd_n) ? exp_rd(a, i_pa, i_pb, i_pc) : 8'h00;
      n_tests++; if (o_data !== exp) begin n_fail++; $display("FAIL rnd_rd it=%0d addr=%0d got=%h want=%h", it, a, o_data, exp); end
      wr = !i_cs_n && !i_wr_n;
      @(posedge i_clk);
      if (rst) model_reset();
      else if (wr) model_write(a, d);
      #1;
      reset_n = 1'b1;
      n_tests++; if ({o_pa, o_pb, o_pc} !== {exp_pin(0), exp_pin(1), exp_pin(2)})
        begin n_fail++; $display("FAIL rnd_pins it=%0d got=%h want=%h", it, {o_pa, o_pb, o_pc}, {exp_pin(0), exp_pin(1), exp_pin(2)}); end
    end
    i_cs_n = 1'b1; i_wr_n = 1'b1; i_rd_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge i_clk); #1;
    test_reset();
    test_mode0();
    test_pc_nibbles();
    test_bsr();
    test_modeset_clears();
    test_rd_wr_same_cycle();
    test_reset_override();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
